// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the team FIFO family (sync_fifo, async FIFO).
//   clog2       : pointer-width helper, never returns less than 1
//   FWFT_OFF/ON : read-mode selector values
//   *_ok        : parameter range checks used at elaboration time
//   fifo_flags_t: decoded status flags bundle
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
  } fifo_flags_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic bit depth_ok(input int depth);
    return depth >= 2;
  endfunction

  function automatic bit af_level_ok(input int depth, input int af_level);
    return (af_level >= 1) && (af_level <= depth);
  endfunction

  function automatic bit ae_level_ok(input int depth, input int ae_level);
    return (ae_level >= 0) && (ae_level <= depth - 1);
  endfunction

  function automatic bit fwft_ok(input int fwft);
    return (fwft == FWFT_OFF) || (fwft == FWFT_ON);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// ---------------------------------------------------------------------------
// sync_fifo_mem
// Single-clock flop-array storage for sync_fifo.
//   i_clk    : clock, rising edge
//   i_rst    : synchronous clear of every entry and of the read register
//   i_we     : write strobe (already qualified by the caller)
//   i_waddr  : write address, 0..DEPTH-1
//   i_wdata  : write data
//   i_re     : read strobe (already qualified); used only in registered mode
//   i_raddr  : read address, 0..DEPTH-1
//   o_rdata  : registered (FWFT_OFF) or combinational (FWFT_ON) read data
// ---------------------------------------------------------------------------
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter  int D_WIDTH    = 8,
  parameter  int DEPTH      = 16,
  parameter  int FWFT       = FWFT_OFF,
  localparam int ADDR_WIDTH = clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [D_WIDTH-1:0]    i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [D_WIDTH-1:0]    o_rdata
);

  logic [D_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  generate
    if (FWFT == FWFT_ON) begin : g_fwft
      // The head entry is shown directly; the pop strobe only moves the
      // caller's read pointer, so it has no job here.
      logic w_unused_re;
      assign w_unused_re = i_re;
      assign o_rdata     = r_mem[i_raddr];
    end else begin : g_reg
      logic [D_WIDTH-1:0] r_rdata;
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_rdata <= '0;
        end else if (i_re) begin
          r_rdata <= r_mem[i_raddr];
        end
      end
      assign o_rdata = r_rdata;
    end
  endgenerate

endmodule

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock elastic buffer with arbitrary depth, occupancy count,
// programmable almost-full/almost-empty levels, overflow/underflow pulses
// and selectable first-word-fall-through read.
//   i_clk          : clock, rising edge
//   i_rst          : synchronous reset, active high, dominates w/r requests
//   i_w_en         : write request
//   i_w_data       : write data
//   i_r_en         : read (pop) request
//   o_r_data       : read data
//   o_full         : count == DEPTH
//   o_almost_full  : count >= AF_LEVEL
//   o_empty        : count == 0
//   o_almost_empty : count <= AE_LEVEL
//   o_count        : occupancy 0..DEPTH
//   o_overflow     : one-cycle pulse after a rejected write
//   o_underflow    : one-cycle pulse after a rejected read
// ---------------------------------------------------------------------------
module sync_fifo
  import fifo_pkg::*;
#(
  parameter  int D_WIDTH    = 8,
  parameter  int DEPTH      = 16,
  parameter  int AF_LEVEL   = DEPTH - 2,
  parameter  int AE_LEVEL   = 2,
  parameter  int FWFT       = FWFT_OFF,
  localparam int ADDR_WIDTH = clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_w_en,
  input  logic [D_WIDTH-1:0]    i_w_data,
  input  logic                  i_r_en,
  output logic [D_WIDTH-1:0]    o_r_data,
  output logic                  o_full,
  output logic                  o_almost_full,
  output logic                  o_empty,
  output logic                  o_almost_empty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  generate
    if (!depth_ok(DEPTH)) begin : g_bad_depth
      $error("sync_fifo: DEPTH must be at least 2");
    end
    if (!af_level_ok(DEPTH, AF_LEVEL)) begin : g_bad_af
      $error("sync_fifo: AF_LEVEL must be in 1..DEPTH");
    end
    if (!ae_level_ok(DEPTH, AE_LEVEL)) begin : g_bad_ae
      $error("sync_fifo: AE_LEVEL must be in 0..DEPTH-1");
    end
    if (!fwft_ok(FWFT)) begin : g_bad_fwft
      $error("sync_fifo: FWFT must be FWFT_OFF or FWFT_ON");
    end
  endgenerate

  localparam int                  CW       = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CW-1:0]       FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]       AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0]       AE_CNT   = CW'(AE_LEVEL);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  fifo_flags_t           w_flags;
  logic                  w_wr_acc;
  logic                  w_rd_acc;

  // Explicit wrap so non-power-of-two depths never address past the array.
  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  // Flags come from the registered count only, never from the requests.
  always_comb begin
    w_flags              = '0;
    w_flags.full         = (r_count == FULL_CNT);
    w_flags.almost_full  = (r_count >= AF_CNT);
    w_flags.empty        = (r_count == '0);
    w_flags.almost_empty = (r_count <= AE_CNT);
  end

  assign w_wr_acc = i_w_en && !w_flags.full;
  assign w_rd_acc = i_r_en && !w_flags.empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_overflow  <= i_w_en && w_flags.full;
      r_underflow <= i_r_en && w_flags.empty;
    end
  end

  sync_fifo_mem #(
    .D_WIDTH (D_WIDTH),
    .DEPTH   (DEPTH),
    .FWFT    (FWFT)
  ) u_mem (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_w_data),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr),
    .o_rdata (o_r_data)
  );

  assign o_full         = w_flags.full;
  assign o_almost_full  = w_flags.almost_full;
  assign o_empty        = w_flags.empty;
  assign o_almost_empty = w_flags.almost_empty;
  assign o_count        = r_count;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule
